bias_add_stream: RTL and testbench
==================================

Name: bias_add_stream

Overview:
- Consumer at the far end of the per-layer bias coefficient stream. Reads NUM_KERNELS bias words through an ap_fifo read interface into a local table.
- Then adds the matching per-channel bias to each convolution accumulator word arriving on a second ap_fifo read interface.
- Emits saturated results on an ap_fifo write interface toward the activation stage.
- Reloads the bias table at the start of every frame.

Parameters:
- NUM_KERNELS, 16, output channels, equal to the bias table depth (>=2).
- PIXELS, 64, output pixels per frame; a frame is PIXELS*NUM_KERNELS accumulator words.
- COEFF_WIDTH, 16, bias word width, signed two's complement.
- ACC_WIDTH, 32, accumulator and result width, signed two's complement.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- bias_V_dout  in  COEFF_WIDTH  bias word at the FIFO head.
- bias_V_empty_n  in  1  bias FIFO non-empty.
- bias_V_read  out  1  pops the bias FIFO at the clock edge.
- acc_V_dout  in  ACC_WIDTH  accumulator word at the FIFO head.
- acc_V_empty_n  in  1  accumulator FIFO non-empty.
- acc_V_read  out  1  pops the accumulator FIFO at the clock edge.
- output_V_din  out  ACC_WIDTH  biased, saturated result.
- output_V_full_n  in  1  output FIFO not full.
- output_V_write  out  1  pushes output_V_din at the clock edge.
- table_ready  out  1  high while in RUN, i.e. the bias table is loaded.

Behaviour:
- Reset (ap_rst=1 at an edge): state=LOAD, load_idx=0, ch=0, pix=0, out_valid=0, out_reg=0.
  - All outputs 0 in the following cycle.
  - Table contents are don't-care.
  - Reset mid-frame discards any partial table and any pending output.
- Handshake semantics are ap_fifo: a word transfers at an edge when read&empty_n, or write&full_n.
  - read/write are asserted only when empty_n/full_n is high, so a handshake is never asserted without a transfer.
- LOAD state:
  - bias_V_read = bias_V_empty_n. On a pop, table[load_idx] <= bias_V_dout and load_idx increments.
  - A pop with load_idx==NUM_KERNELS-1 sets load_idx=0 and moves to RUN.
  - acc_V_read=0 and table_ready=0.
  - out_valid may still drain a final result from the previous frame; output_V_write behaves as in RUN.
- RUN state:
  - bias_V_read=0 and table_ready=1.
  - can_accept = !out_valid | output_V_full_n.
  - acc_V_read = acc_V_empty_n & can_accept.
  - On an accumulator pop: out_reg <= sat(acc_V_dout + sext(table[ch])) and out_valid <= 1.
  - ch wraps at NUM_KERNELS-1. On each wrap pix increments.
  - A pop with ch==NUM_KERNELS-1 and pix==PIXELS-1 sets ch=0, pix=0 and returns to LOAD.
- Output:
  - output_V_din = out_reg and output_V_write = out_valid & output_V_full_n.
  - out_valid clears on a write unless a pop in the same cycle refills it. Simultaneous write and pop gives full throughput of 1 word/cycle.
- Latency: exactly 1 cycle from accumulator pop to output_V_write=1, given full_n=1.
- Backpressure: while full_n=0 and out_valid=1, no accumulator pop occurs; out_reg and ch are held.
- Arithmetic:
  - The sum is computed at ACC_WIDTH+1 bits.
  - Positive overflow gives 2^(ACC_WIDTH-1)-1; negative overflow gives -2^(ACC_WIDTH-1).
  - No rounding.
- Bias words arriving during RUN are left in the FIFO and not consumed.

Decomposition:
- Shared package holds:
  - COEFF_WIDTH/ACC_WIDTH defaults.
  - Typedefs coeff_t and acc_t.
  - State enum {LOAD, RUN}.
  - Function sat_add(acc_t, coeff_t) returning acc_t.
- One sub-module: bias_table_rf.
  - NUM_KERNELS x COEFF_WIDTH register file.
  - Single write port (we, waddr, wdata) and an asynchronous read port (raddr=ch).
  - No reset on its contents.

Test Plan:
- Load biases 0..15 (NUM_KERNELS=16), then feed 32 accumulators all =100, output FIFO always ready -> outputs 100,101..115,100..115, each 1 cycle after its pop; table_ready rises the cycle after the 16th bias pop.
- Accumulator 0x7FFFFFF0 with bias +0x0100 -> 0x7FFFFFFF. Accumulator 0x80000010 with bias -0x0100 -> 0x80000000.
- Hold output_V_full_n=0 for 5 cycles while out_valid=1 -> acc_V_read stays 0, output_V_din stable, no word lost or duplicated. Resume gives in-order output.
- PIXELS=2: after 32 pops table_ready falls, bias_V_read resumes, and the second frame uses the new bias set 200..215 -> acc 0 yields 200..215.
- Assert ap_rst after 7 bias pops, then reload 16 fresh biases -> table reflects only the post-reset words; all outputs 0 during reset.
- Random empty_n/full_n toggling over 3 frames against a reference model -> bit-exact match, with no read while empty_n=0 and no write while full_n=0.

Source files
------------

// File: rtl/bias_add_stream_pkg.sv
// bias_add_stream_pkg: shared types, state encoding and saturating bias add for bias_add_stream
package bias_add_stream_pkg;
  localparam int DEF_COEFF_WIDTH = 16;
  localparam int DEF_ACC_WIDTH = 32;
  typedef logic signed [DEF_COEFF_WIDTH-1:0] coeff_t;
  typedef logic signed [DEF_ACC_WIDTH-1:0] acc_t;
  typedef enum logic {LOAD, RUN} state_t;
  function automatic acc_t sat_add(acc_t a, coeff_t b);
    logic signed [DEF_ACC_WIDTH:0] s;
    s = {a[DEF_ACC_WIDTH-1], a} + {{(DEF_ACC_WIDTH+1-DEF_COEFF_WIDTH){b[DEF_COEFF_WIDTH-1]}}, b};
    return (s[DEF_ACC_WIDTH] != s[DEF_ACC_WIDTH-1]) ?
      {s[DEF_ACC_WIDTH], {(DEF_ACC_WIDTH-1){~s[DEF_ACC_WIDTH]}}} : s[DEF_ACC_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/bias_table_rf.sv
// bias_table_rf: per-channel bias register file, one write port, asynchronous read, no reset
module bias_table_rf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/bias_add_stream.sv
// bias_add_stream: loads a per-frame bias table from one ap_fifo, then adds it to an accumulator stream with saturation
module bias_add_stream
  import bias_add_stream_pkg::*;
#(
  parameter int NUM_KERNELS = 16,
  parameter int PIXELS = 64,
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [COEFF_WIDTH-1:0] bias_V_dout,
  input  logic                   bias_V_empty_n,
  output logic                   bias_V_read,
  input  logic [ACC_WIDTH-1:0]   acc_V_dout,
  input  logic                   acc_V_empty_n,
  output logic                   acc_V_read,
  output logic [ACC_WIDTH-1:0]   output_V_din,
  input  logic                   output_V_full_n,
  output logic                   output_V_write,
  output logic                   table_ready
);
  localparam int KW = NUM_KERNELS > 1 ? $clog2(NUM_KERNELS) : 1;
  localparam int PW = PIXELS > 1 ? $clog2(PIXELS) : 1;
  state_t state, state_nxt;
  logic [KW-1:0] load_idx, ch;
  logic [PW-1:0] pix;
  logic out_valid;
  acc_t out_reg;
  coeff_t bias_rd;
  logic bias_pop, acc_pop, load_last, ch_last, pix_last;
  bias_table_rf #(.DEPTH(NUM_KERNELS), .WIDTH(COEFF_WIDTH)) u_table (
    .clk(ap_clk),
    .we(bias_pop),
    .waddr(load_idx),
    .wdata(bias_V_dout),
    .raddr(ch),
    .rdata(bias_rd)
  );
  always_comb begin
    bias_pop = !ap_rst && state == LOAD && bias_V_empty_n;
    acc_pop = !ap_rst && state == RUN && acc_V_empty_n && (!out_valid || output_V_full_n);
    load_last = load_idx == KW'(NUM_KERNELS - 1);
    ch_last = ch == KW'(NUM_KERNELS - 1);
    pix_last = pix == PW'(PIXELS - 1);
    state_nxt = bias_pop && load_last ? RUN : acc_pop && ch_last && pix_last ? LOAD : state;
  end
  assign bias_V_read = bias_pop;
  assign acc_V_read = acc_pop;
  assign output_V_din = out_reg;
  assign output_V_write = out_valid && output_V_full_n;
  assign table_ready = state == RUN;
  always_ff @(posedge ap_clk) state <= ap_rst ? LOAD : state_nxt;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      load_idx <= '0;
      ch <= '0;
      pix <= '0;
      out_valid <= 1'b0;
      out_reg <= '0;
    end else begin
      if (bias_pop) load_idx <= load_last ? '0 : load_idx + 1'b1;
      if (acc_pop) begin
        ch <= ch_last ? '0 : ch + 1'b1;
        if (ch_last) pix <= pix_last ? '0 : pix + 1'b1;
        out_reg <= sat_add(acc_V_dout, bias_rd);
      end
      out_valid <= acc_pop || (out_valid && !output_V_full_n);
    end
  end
endmodule

// File: tb/tb_bias_add_stream.sv
// tb_bias_add_stream: randomized scoreboard bench for bias_add_stream against a frame/channel reference model
module tb_bias_add_stream;
  localparam int N = 16;
  localparam int P = 2;
  logic ap_clk = 1'b0;
  logic ap_rst;
  logic [15:0] bias_V_dout;
  logic bias_V_empty_n, bias_V_read;
  logic [31:0] acc_V_dout;
  logic acc_V_empty_n, acc_V_read;
  logic [31:0] output_V_din;
  logic output_V_full_n, output_V_write, table_ready;
  logic [15:0] bias_q[$], bias_hist[$];
  logic [31:0] acc_q[$], exp_q[$];
  int pop_cyc[$];
  int bias_rate = 100, acc_rate = 100, full_rate = 100;
  bit full_low = 0, lat_chk = 0;
  int cyc = 0, acc_n = 0, n_chk = 0, n_fail = 0;
  bias_add_stream #(.NUM_KERNELS(N), .PIXELS(P), .COEFF_WIDTH(16), .ACC_WIDTH(32)) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bias_V_dout(bias_V_dout),
    .bias_V_empty_n(bias_V_empty_n),
    .bias_V_read(bias_V_read),
    .acc_V_dout(acc_V_dout),
    .acc_V_empty_n(acc_V_empty_n),
    .acc_V_read(acc_V_read),
    .output_V_din(output_V_din),
    .output_V_full_n(output_V_full_n),
    .output_V_write(output_V_write),
    .table_ready(table_ready)
  );
  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc++;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic timeout(input string name, input int pending);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out with %0d pending, expected 0", name, pending);
  endtask
  function automatic logic [31:0] ref_sat(input logic [31:0] a, input logic [15:0] b);
    longint s, hi, lo;
    hi = (longint'(1) <<< 31) - 1;
    lo = -(longint'(1) <<< 31);
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > hi) return 32'h7FFF_FFFF;
    if (s < lo) return 32'h8000_0000;
    return s[31:0];
  endfunction
  task automatic push_bias(input logic [15:0] b);
    bias_q.push_back(b);
    bias_hist.push_back(b);
  endtask
  task automatic push_acc(input logic [31:0] a);
    int f, c, idx;
    f = acc_n / (N * P);
    c = acc_n % N;
    idx = f * N + c;
    acc_n++;
    acc_q.push_back(a);
    exp_q.push_back(ref_sat(a, idx < bias_hist.size() ? bias_hist[idx] : 16'h0));
  endtask
  function automatic logic [31:0] rand_acc();
    int sel;
    sel = $urandom_range(3);
    if (sel == 0) return {16'h7FFF, 16'($urandom)};
    if (sel == 1) return {16'h8000, 16'($urandom)};
    return $urandom;
  endfunction
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((acc_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= budget) timeout("drain", exp_q.size());
    repeat (2) @(negedge ap_clk);
  endtask
  task automatic wait_ready(input logic lvl, input int budget);
    int n;
    n = 0;
    while (table_ready !== lvl && n < budget) begin
      @(negedge ap_clk);
      #3;
      n++;
    end
    if (n >= budget) timeout("table_ready_wait", 1);
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_bias_read"}, {31'd0, bias_V_read}, 0);
    check({tag, "_acc_read"}, {31'd0, acc_V_read}, 0);
    check({tag, "_write"}, {31'd0, output_V_write}, 0);
    check({tag, "_din"}, output_V_din, 0);
    check({tag, "_table_ready"}, {31'd0, table_ready}, 0);
  endtask
  always @(negedge ap_clk) begin
    bias_V_empty_n = bias_q.size() != 0 && $urandom_range(99) < bias_rate;
    bias_V_dout = bias_q.size() != 0 ? bias_q[0] : 16'h0;
    acc_V_empty_n = acc_q.size() != 0 && $urandom_range(99) < acc_rate;
    acc_V_dout = acc_q.size() != 0 ? acc_q[0] : 32'h0;
    output_V_full_n = !full_low && $urandom_range(99) < full_rate;
    #1;
    if (bias_V_read && bias_V_empty_n) void'(bias_q.pop_front());
    if (acc_V_read && acc_V_empty_n) begin
      void'(acc_q.pop_front());
      pop_cyc.push_back(cyc);
    end
  end
  always @(negedge ap_clk) begin
    #2;
    check("handshake", {29'd0, bias_V_read & !bias_V_empty_n, acc_V_read & !acc_V_empty_n,
                        output_V_write & !output_V_full_n}, 0);
    if (output_V_write && output_V_full_n) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got %h expected no output", output_V_din);
      end else begin
        check("out_data", output_V_din, exp_q.pop_front());
        if (pop_cyc.size() != 0) begin
          if (lat_chk) check("latency", cyc - pop_cyc[0], 1);
          void'(pop_cyc.pop_front());
        end
      end
    end
  end
  initial begin
    int k, n;
    logic [31:0] held;
    ap_rst = 1'b1;
    bias_V_empty_n = 1'b0;
    acc_V_empty_n = 1'b0;
    output_V_full_n = 1'b1;
    bias_V_dout = '0;
    acc_V_dout = '0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    #3;
    check_idle("reset");
    @(posedge ap_clk);
    #2;
    ap_rst = 1'b0;
    for (int i = 0; i < N; i++) push_bias(16'(i));
    k = 0;
    n = 0;
    while (k < N && n < 200) begin
      @(negedge ap_clk);
      #3;
      check("table_ready_load", {31'd0, table_ready}, 0);
      if (bias_V_read && bias_V_empty_n) k++;
      n++;
    end
    if (k < N) timeout("bias_load", N - k);
    @(negedge ap_clk);
    #3;
    check("table_ready_rise", {31'd0, table_ready}, 1);
    lat_chk = 1;
    for (int i = 0; i < N * P; i++) push_acc(32'd100);
    wait_drain(300);
    lat_chk = 0;
    #3;
    check("table_ready_fall", {31'd0, table_ready}, 0);
    for (int i = 0; i < N; i++) push_bias(16'(200 + i));
    for (int i = 0; i < N; i++) push_bias(i == 0 ? 16'h0100 : i == 1 ? 16'hFF00 : 16'($urandom));
    @(negedge ap_clk);
    #3;
    check("bias_read_resume", {31'd0, bias_V_read}, 1);
    wait_ready(1'b1, 200);
    repeat (3) @(negedge ap_clk);
    #3;
    check("bias_hold_read", {31'd0, bias_V_read}, 0);
    check("bias_hold_level", bias_q.size(), N);
    for (int i = 0; i < N * P; i++) push_acc(32'd0);
    wait_drain(300);
    push_acc(32'h7FFF_FFF0);
    push_acc(32'h8000_0010);
    for (int i = 2; i < N * P; i++) push_acc(rand_acc());
    n = 0;
    while (acc_q.size() > 20 && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 200) timeout("hold_start", acc_q.size());
    @(posedge ap_clk);
    #2;
    full_low = 1;
    @(negedge ap_clk);
    #3;
    held = output_V_din;
    repeat (5) begin
      @(negedge ap_clk);
      #3;
      check("hold_acc_read", {31'd0, acc_V_read}, 0);
      check("hold_din", output_V_din, held);
    end
    @(posedge ap_clk);
    #2;
    full_low = 0;
    wait_drain(300);
    for (int i = 0; i < 7; i++) push_bias(16'($urandom));
    n = 0;
    while (bias_q.size() != 0 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 100) timeout("partial_load", bias_q.size());
    @(posedge ap_clk);
    #2;
    for (int i = 0; i < 9; i++) push_bias(16'($urandom));
    ap_rst = 1'b1;
    @(posedge ap_clk);
    repeat (2) begin
      @(negedge ap_clk);
      #3;
      check_idle("midload_rst");
    end
    @(posedge ap_clk);
    #2;
    bias_q.delete();
    bias_hist.delete();
    pop_cyc.delete();
    acc_n = 0;
    ap_rst = 1'b0;
    for (int i = 0; i < N; i++) push_bias(16'($urandom));
    for (int i = 0; i < N * P; i++) push_acc(rand_acc());
    wait_drain(400);
    bias_rate = 50;
    acc_rate = 60;
    full_rate = 55;
    for (int i = 0; i < 3 * N; i++) push_bias(16'($urandom));
    for (int i = 0; i < 3 * N * P; i++) push_acc(rand_acc());
    wait_drain(5000);
    bias_rate = 100;
    acc_rate = 100;
    full_rate = 100;
    #3;
    check("final_table_ready", {31'd0, table_ready}, 0);
    check("final_leftover", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
